// File: rtl/servo_pkg.sv
// Shared types and helpers for the three-axis servo PWM driver.
package servo_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned US_PER_S = 1_000_000;

  // Pulse width in microseconds for an 8-bit position; product kept at 32 bits
  function automatic logic [31:0] pulse_width(input logic [7:0]  pos,
                                              input int unsigned min_us,
                                              input int unsigned max_us);
    logic [31:0] span;
    logic [31:0] prod;
    span = max_us - min_us;
    prod = {24'd0, pos} * span;
    return min_us + (prod >> 8);
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo axis: slew-limited position register, pulse width and PWM compare.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned PULSE_MIN_US = 1000,
  parameter int unsigned PULSE_MAX_US = 2000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned POS_RESET    = 128,
  parameter int unsigned US_W         = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      target,
  input  logic            update,
  input  logic            active,
  input  logic [US_W-1:0] us_cnt,
  output logic            pwm,
  output logic [7:0]      pos
);

  localparam logic [7:0] POS_INIT = 8'(POS_RESET);
  localparam logic [8:0] STEP_LIM = (STEP > 255) ? 9'd255 : 9'(STEP);

  logic [8:0]  diff;
  logic [7:0]  pos_next;
  logic [31:0] width;
  logic [31:0] us_ext;

  // Next position: move toward target by at most STEP, never past it
  always_comb begin
    diff     = '0;
    pos_next = pos;
    if (STEP == 0) begin
      pos_next = target;
    end else if (target > pos) begin
      diff = {1'b0, target} - {1'b0, pos};
      if (diff > STEP_LIM) diff = STEP_LIM;
      pos_next = pos + diff[7:0];
    end else if (target < pos) begin
      diff = {1'b0, pos} - {1'b0, target};
      if (diff > STEP_LIM) diff = STEP_LIM;
      pos_next = pos - diff[7:0];
    end
  end

  // Position register, advanced only at a frame end while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= POS_INIT;
    end else if (update) begin
      pos <= pos_next;
    end
  end

  // Pulse width derived from the current position
  always_comb begin
    width  = pulse_width(pos, PULSE_MIN_US, PULSE_MAX_US);
    us_ext = 32'(us_cnt);
  end

  // Registered PWM output: high while the frame counter is below the width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= active && (us_ext < width);
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Three-axis hobby-servo PWM driver: microsecond prescaler, frame counter,
// OFF/RUN/DRAIN sequencing and three slew-limited channels.
// Optional target clamping is built when SERVO_LIMIT_EN is defined.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned FRAME_US     = 20000,
  parameter int unsigned PULSE_MIN_US = 1000,
  parameter int unsigned PULSE_MAX_US = 2000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned POS_RESET    = 128
`ifdef SERVO_LIMIT_EN
  ,
  parameter int unsigned POS_LO       = 16,
  parameter int unsigned POS_HI       = 240
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] target_x,
  input  logic [7:0] target_y,
  input  logic [7:0] target_z,
  output logic       pwm_x,
  output logic       pwm_y,
  output logic       pwm_z,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic [7:0] pos_z,
  output logic       frame_start,
  output logic       settled
);

  localparam int unsigned DIV   = CLK_HZ / US_PER_S;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);

  state_t           state;
  state_t           state_next;
  logic [PRE_W-1:0] presc;
  logic [US_W-1:0]  us_cnt;
  logic             tick;
  logic             frame_end;
  logic             update;
  logic             active;
  logic [7:0]       tgt_x;
  logic [7:0]       tgt_y;
  logic [7:0]       tgt_z;

`ifdef SERVO_LIMIT_EN
  localparam logic [7:0] LO = 8'(POS_LO);
  localparam logic [7:0] HI = 8'(POS_HI);

  function automatic logic [7:0] clamp_pos(input logic [7:0] t);
    if (t < LO)      return LO;
    else if (t > HI) return HI;
    else             return t;
  endfunction

  // Targets limited to the permitted travel before slewing
  always_comb begin
    tgt_x = clamp_pos(target_x);
    tgt_y = clamp_pos(target_y);
    tgt_z = clamp_pos(target_z);
  end
`else
  // Full travel range, targets used as given
  always_comb begin
    tgt_x = target_x;
    tgt_y = target_y;
    tgt_z = target_z;
  end
`endif

  // Microsecond tick and frame-end decode; with DIV==1 presc stays 0 so tick is constant
  always_comb begin
    active    = (state != OFF);
    tick      = (presc == PRE_LAST);
    frame_end = active && tick && (us_cnt == US_LAST);
    update    = frame_end && (state == RUN);
  end

  // Prescaler and frame counter: held at zero while OFF, free-running otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (state == OFF) begin
      presc  <= '0;
      us_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next state: DRAIN finishes the current frame unless enable returns
  always_comb begin
    state_next = state;
    unique case (state)
      OFF:     if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)         state_next = RUN;
        else if (frame_end) state_next = OFF;
      end
      default: state_next = OFF;
    endcase
  end

  // Frame marker and settle indication
  always_comb begin
    frame_start = frame_end;
    settled     = (pos_x == tgt_x) && (pos_y == tgt_y) && (pos_z == tgt_z);
  end

  servo_channel #(
    .PULSE_MIN_US (PULSE_MIN_US),
    .PULSE_MAX_US (PULSE_MAX_US),
    .STEP         (STEP),
    .POS_RESET    (POS_RESET),
    .US_W         (US_W)
  ) u_chan_x (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_x),
    .update (update),
    .active (active),
    .us_cnt (us_cnt),
    .pwm    (pwm_x),
    .pos    (pos_x)
  );

  servo_channel #(
    .PULSE_MIN_US (PULSE_MIN_US),
    .PULSE_MAX_US (PULSE_MAX_US),
    .STEP         (STEP),
    .POS_RESET    (POS_RESET),
    .US_W         (US_W)
  ) u_chan_y (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_y),
    .update (update),
    .active (active),
    .us_cnt (us_cnt),
    .pwm    (pwm_y),
    .pos    (pos_y)
  );

  servo_channel #(
    .PULSE_MIN_US (PULSE_MIN_US),
    .PULSE_MAX_US (PULSE_MAX_US),
    .STEP         (STEP),
    .POS_RESET    (POS_RESET),
    .US_W         (US_W)
  ) u_chan_z (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_z),
    .update (update),
    .active (active),
    .us_cnt (us_cnt),
    .pwm    (pwm_z),
    .pos    (pos_z)
  );

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver: 1 MHz clock (one tick per cycle),
// 2000 us frames to keep the run short; a second instance uses STEP=0.
module tb_servo_pwm_driver;

  localparam int unsigned FRAME = 2000;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [7:0] target_x, target_y, target_z;
  logic       pwm_x, pwm_y, pwm_z;
  logic [7:0] pos_x, pos_y, pos_z;
  logic       frame_start, settled;

  logic       rst0, en0;
  logic [7:0] t0_x, t0_y, t0_z;
  logic       pwm0_x, pwm0_y, pwm0_z;
  logic [7:0] pos0_x, pos0_y, pos0_z;
  logic       fs0, settled0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          done0 = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .CLK_HZ       (1_000_000),
    .FRAME_US     (FRAME),
    .PULSE_MIN_US (1000),
    .PULSE_MAX_US (2000),
    .STEP         (4),
    .POS_RESET    (128)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable),
    .target_x (target_x), .target_y (target_y), .target_z (target_z),
    .pwm_x (pwm_x), .pwm_y (pwm_y), .pwm_z (pwm_z),
    .pos_x (pos_x), .pos_y (pos_y), .pos_z (pos_z),
    .frame_start (frame_start), .settled (settled)
  );

  servo_pwm_driver #(
    .CLK_HZ       (1_000_000),
    .FRAME_US     (FRAME),
    .PULSE_MIN_US (1000),
    .PULSE_MAX_US (2000),
    .STEP         (0),
    .POS_RESET    (128)
  ) dut0 (
    .clk (clk), .rst (rst0), .enable (en0),
    .target_x (t0_x), .target_y (t0_y), .target_z (t0_z),
    .pwm_x (pwm0_x), .pwm_y (pwm0_y), .pwm_z (pwm0_z),
    .pos_x (pos0_x), .pos_y (pos0_y), .pos_z (pos0_z),
    .frame_start (fs0), .settled (settled0)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to the next frame_start on the main instance (bounded)
  task automatic wait_fs(input string tag);
    int unsigned k = 0;
    step();
    while (!frame_start && k < 2 * FRAME + 8) begin
      step();
      k++;
    end
    if (!frame_start) check({tag, " timeout"}, 0, 1);
  endtask

  // From a frame_start sample, measure the period and pwm_x high time
  task automatic measure(input string tag, input int unsigned exp_hi);
    int unsigned cnt = 0;
    int unsigned hi  = 0;
    do begin
      step();
      cnt++;
      hi += int'(pwm_x);
    end while (!frame_start && cnt < 2 * FRAME);
    check({tag, " period"}, cnt, FRAME);
    check({tag, " width"}, hi, exp_hi);
  endtask

  // STEP=0 instance: immediate jump to target at frame end
  initial begin : step0_seq
    int unsigned k;
    int unsigned hi;
    rst0 = 1'b1; en0 = 1'b0;
    t0_x = 8'd128; t0_y = 8'd0; t0_z = 8'd128;
    step(3);
    rst0 = 1'b0;
    en0  = 1'b1;
    k = 0;
    do begin step(); k++; end while (!fs0 && k < 2 * FRAME + 8);
    check("s0 first fs", int'(fs0), 1);
    step();
    check("s0 pos_y to 0", pos0_y, 0);
    t0_y = 8'd200;
    k = 0;
    do begin step(); k++; end while (!fs0 && k < 2 * FRAME + 8);
    check("s0 fs gap", k, FRAME - 1);
    step();
    check("s0 pos_y to 200", pos0_y, 200);
    check("s0 settled", int'(settled0), 1);
    hi = 0;
    repeat (FRAME) begin step(); hi += int'(pwm0_y); end
    check("s0 width y", hi, 1781);
    done0 = 1'b1;
  end

  initial begin : main_seq
    int unsigned k;
    int unsigned fsn;
    int unsigned hi;

    rst = 1'b1; enable = 1'b0;
    target_x = 8'd128; target_y = 8'd128; target_z = 8'd128;
    step(3);
    rst = 1'b0;
    step();
    check("rst pos_x", pos_x, 128);
    check("rst pos_y", pos_y, 128);
    check("rst pos_z", pos_z, 128);
    check("rst pwm", int'(pwm_x | pwm_y | pwm_z), 0);
    check("rst settled", int'(settled), 1);
    fsn = 0; hi = 0;
    repeat (300) begin step(); fsn += int'(frame_start); hi += int'(pwm_x); end
    check("idle fs", fsn, 0);
    check("idle pwm", hi, 0);

    // Steady run at centre position
    enable = 1'b1;
    step();
    check("entry fs", int'(frame_start), 0);
    k = 1;
    while (!frame_start && k < 2 * FRAME + 8) begin step(); k++; end
    check("first frame len", k, FRAME);
    measure("run128", 1500);
    check("run128 pos_x", pos_x, 128);

    // Slew x from 128 to 255 at 4 per frame, last step 3
    step();
    target_x = 8'd255;
    wait_fs("ramp1");
    step();
    check("ramp pos_x f1", pos_x, 132);
    check("ramp settled f1", int'(settled), 0);
    for (int f = 2; f <= 31; f++) begin
      wait_fs($sformatf("ramp%0d", f));
      step();
    end
    check("ramp pos_x f31", pos_x, 252);
    check("ramp settled f31", int'(settled), 0);
    wait_fs("ramp32");
    step();
    check("ramp pos_x f32", pos_x, 255);
    check("ramp settled f32", int'(settled), 1);
    hi = 0;
    repeat (FRAME) begin step(); hi += int'(pwm_x); end
    check("ramp width 255", hi, 1996);

    // Reset in the middle of a pulse
    wait_fs("pre-rst");
    step(600);
    check("pre-rst pwm_x", int'(pwm_x), 1);
    rst = 1'b1;
    #1;
    check("rst pwm_x now", int'(pwm_x), 0);
    check("rst pos_x now", pos_x, 128);
    target_x = 8'd128;
    enable   = 1'b0;
    step(2);
    rst = 1'b0;
    fsn = 0; hi = 0;
    repeat (500) begin step(); fsn += int'(frame_start); hi += int'(pwm_x); end
    check("post-rst fs", fsn, 0);
    check("post-rst pwm", hi, 0);

    // Enable dropped at us_cnt=500: pulse completes, one last frame end, then OFF
    enable = 1'b1;
    step();
    step(500);
    check("drain pre-drop pwm", int'(pwm_x), 1);
    enable = 1'b0;
    step(1000);
    check("drain pulse tail", int'(pwm_x), 1);
    step();
    check("drain pulse end", int'(pwm_x), 0);
    k = 0;
    do begin step(); k++; end while (!frame_start && k < 2 * FRAME);
    check("drain final fs", k, 498);
    fsn = 0; hi = 0;
    repeat (FRAME + 100) begin step(); fsn += int'(frame_start); hi += int'(pwm_x); end
    check("off fs", fsn, 0);
    check("off pwm", hi, 0);
    check("off pos_x", pos_x, 128);

    // Re-enable during DRAIN keeps the frame grid
    enable = 1'b1;
    step();
    wait_fs("rerun");
    step(100);
    enable = 1'b0;
    step(100);
    enable = 1'b1;
    k = 0;
    do begin step(); k++; end while (!frame_start && k < 2 * FRAME);
    check("reenable fs gap", k, FRAME - 200);
    measure("reenable", 1500);

    k = 0;
    while (!done0 && k < 20000) begin step(); k++; end
    check("step0 done", int'(done0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
